alu_seq: RTL

Parametrised, multi-cycle integer ALU with valid/ready handshakes on input and output. It is the clocked successor to the combinational integer ALU. Its operations and op encoding match the combinational ALU's integer low opcode bits. Single-cycle logic/add paths sit alongside iterative signed multiply and divide. It sits between the operand/issue stage and writeback, and can hold a result under backpressure.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_div_iter.sv | 49 ++++
 rtl/alu_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and op classification for alu_seq (ALU_REM_EN enables op 010)
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b111;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_REM = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [2:0] op);
`ifdef ALU_REM_EN
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
`else
        return (op == OP_MUL) || (op == OP_DIV);
`endif
    endfunction

endpackage

// File: rtl/alu_div_iter.sv
// rtl/alu_div_iter.sv - restoring divider over magnitudes, one quotient bit per step (rem port only with ALU_REM_EN)
module alu_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo
`ifdef ALU_REM_EN
    ,
    output logic [WIDTH-1:0] rem
`endif
);

    logic [WIDTH-1:0] rem_r, quo_r, dsr_r, rem_nxt;
    logic [WIDTH:0]   partial, diff;

    // quo/rem are the values after the current step, so the caller can
    // capture the final result on the same edge as the last step.
    always_comb begin
        partial = {rem_r, quo_r[WIDTH-1]};
        diff    = partial - {1'b0, dsr_r};
        rem_nxt = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
        quo     = {quo_r[WIDTH-2:0], ~diff[WIDTH]};
    end

`ifdef ALU_REM_EN
    assign rem = rem_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r <= '0;
            quo_r <= '0;
            dsr_r <= '0;
        end else if (start) begin
            rem_r <= '0;
            quo_r <= dividend;
            dsr_r <= divisor;
        end else if (step) begin
            rem_r <= rem_nxt;
            quo_r <= quo;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle integer ALU with valid/ready handshakes (ALU_REM_EN enables signed remainder)
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             ze,
    output logic             dz,
    output logic             err
);
    import alu_pkg::*;

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_r;
    logic             neg_r, b_zero_r;
    logic [WIDTH-1:0] acc, mcand, mplier, acc_nxt;
    logic [WIDTH-1:0] a_mag, b_mag, quo, res_single, res_multi;
    logic             accept, last, err_single, dz_multi;
`ifdef ALU_REM_EN
    logic [WIDTH-1:0] a_r, rem;
    logic             a_neg_r;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (state == BUSY) && (cnt == CW'(WIDTH - 1));
    assign a_mag     = a[WIDTH-1] ? -a : a;
    assign b_mag     = b[WIDTH-1] ? -b : b;
    assign acc_nxt   = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = is_multicycle(op) ? BUSY : DONE;
            BUSY:    if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        res_single = '0;
        err_single = 1'b0;
        case (op)
            OP_ADD:  res_single = a + b;
            OP_SUB:  res_single = a - b;
            OP_AND:  res_single = a & b;
            OP_OR:   res_single = a | b;
            OP_XOR:  res_single = a ^ b;
            default: err_single = 1'b1;
        endcase
    end

    // Signs are applied only on the final step; the iterations run on magnitudes.
    always_comb begin
        res_multi = neg_r ? -acc_nxt : acc_nxt;
        dz_multi  = 1'b0;
        case (op_r)
            OP_DIV: begin
                dz_multi  = b_zero_r;
                res_multi = b_zero_r ? '1 : (neg_r ? -quo : quo);
            end
`ifdef ALU_REM_EN
            OP_REM: begin
                dz_multi  = b_zero_r;
                res_multi = b_zero_r ? a_r : (a_neg_r ? -rem : rem);
            end
`endif
            default: ;
        endcase
    end

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (accept),
        .step     (state == BUSY),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo      (quo)
`ifdef ALU_REM_EN
        ,
        .rem      (rem)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_r     <= OP_ADD;
            neg_r    <= 1'b0;
            b_zero_r <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            s        <= '0;
            ze       <= 1'b1;
            dz       <= 1'b0;
            err      <= 1'b0;
`ifdef ALU_REM_EN
            a_r      <= '0;
            a_neg_r  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_r     <= op;
                neg_r    <= a[WIDTH-1] ^ b[WIDTH-1];
                b_zero_r <= (b == '0);
                cnt      <= '0;
                acc      <= '0;
                mcand    <= a_mag;
                mplier   <= b_mag;
`ifdef ALU_REM_EN
                a_r      <= a;
                a_neg_r  <= a[WIDTH-1];
`endif
                if (!is_multicycle(op)) begin
                    s   <= res_single;
                    ze  <= (res_single == '0);
                    dz  <= 1'b0;
                    err <= err_single;
                end
            end else if (state == BUSY) begin
                cnt    <= cnt + 1'b1;
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                if (last) begin
                    s   <= res_multi;
                    ze  <= (res_multi == '0);
                    dz  <= dz_multi;
                    err <= 1'b0;
                end
            end
        end
    end

endmodule
